// File: rtl/dtw_result_arbiter.sv
// dtw_result_arbiter
//
// Shares the single DTW result FIFO write port among NUM_CORES compute cores.
// A round-robin pick selects one pending core, its score and position are
// latched, and the record goes out as two FIFO words: a header
// {4'hD, core index, position} followed by the score. A flush request pads
// the current PACKET_WORDS-word packet with all-ones filler, so that the
// stream master can close the packet with TLAST. A flush never splits a
// record.
//
// Ports:
//   ACLK            clock, rising edge
//   ARESET          asynchronous reset, active high
//   core_res_valid  per-core result pending; held until that core's ready pulse
//   core_res_ready  one-hot, single-cycle acceptance pulse
//   core_res_score  packed scores, core i in slice i
//   core_res_pos    packed best-match positions, core i in slice i
//   flush           single-cycle request to pad out the current packet
//   dtw_fifo_wren   FIFO write strobe, never asserted while dtw_fifo_full
//   dtw_fifo_din    FIFO write data, zero while idle
//   dtw_fifo_full   FIFO full
//   busy            a record or pad sequence is in progress, or a flush is pending
//   results_sent    completed-record count, wraps at 2^16
module dtw_result_arbiter #(
  parameter int NUM_CORES    = 4,
  parameter int C_DATA_WIDTH = 32,
  parameter int POS_WIDTH    = 24,
  parameter int PACKET_WORDS = 8
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [NUM_CORES-1:0]              core_res_valid,
  output logic [NUM_CORES-1:0]              core_res_ready,
  input  logic [NUM_CORES*C_DATA_WIDTH-1:0] core_res_score,
  input  logic [NUM_CORES*POS_WIDTH-1:0]    core_res_pos,
  input  logic                              flush,
  output logic                              dtw_fifo_wren,
  output logic [C_DATA_WIDTH-1:0]           dtw_fifo_din,
  input  logic                              dtw_fifo_full,
  output logic                              busy,
  output logic [15:0]                       results_sent
);

  localparam int IDX_W = $clog2(NUM_CORES);
  localparam int WC_W  = $clog2(PACKET_WORDS);
  localparam logic [IDX_W-1:0] LAST_CORE = IDX_W'(NUM_CORES - 1);
  localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(PACKET_WORDS - 1);
  localparam logic [3:0]       HDR_TAG   = 4'hD;

  typedef enum logic [1:0] {IDLE, HDR, SCORE, PAD} state_t;

  state_t                  state, state_d;
  logic [IDX_W-1:0]        last_grant;
  logic [IDX_W-1:0]        idx_q;
  logic [C_DATA_WIDTH-1:0] score_q;
  logic [POS_WIDTH-1:0]    pos_q;
  logic [WC_W-1:0]         word_cnt;
  logic                    flush_pend;

  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        cand;
  logic                    grant_found;
  logic                    take_grant;
  logic                    pend_clear;
  logic [C_DATA_WIDTH-1:0] header;

  // Round-robin pick: first valid core scanning upward from last_grant+1.
  // NOTE: every signal written in an always_comb gets a default at the top, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_CORES);
      if (!grant_found && core_res_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Header word: tag in the top nibble, core index in the next nibble,
  // position in the low bits, everything in between zero.
  always_comb begin
    header                       = '0;
    header[POS_WIDTH-1:0]        = pos_q;
    header[C_DATA_WIDTH-1 -: 4]  = HDR_TAG;
    header[C_DATA_WIDTH-5 -: 4]  = 4'(idx_q);
  end

  // Next state and write port. The strobe depends only on registered state and
  // the full flag, so a write can never land in a full FIFO.
  always_comb begin
    state_d       = state;
    dtw_fifo_wren = 1'b0;
    dtw_fifo_din  = '0;
    take_grant    = 1'b0;
    pend_clear    = 1'b0;
    unique case (state)
      IDLE: begin
        // A pending flush wins over new grants; at a packet boundary there is
        // nothing to pad, so the request simply retires.
        if (flush_pend) begin
          if (word_cnt != '0) state_d = PAD;
          else                pend_clear = 1'b1;
        end else if (grant_found) begin
          take_grant = 1'b1;
          state_d    = HDR;
        end
      end
      HDR: begin
        dtw_fifo_din = header;
        if (!dtw_fifo_full) begin
          dtw_fifo_wren = 1'b1;
          state_d       = SCORE;
        end
      end
      SCORE: begin
        dtw_fifo_din = score_q;
        if (!dtw_fifo_full) begin
          dtw_fifo_wren = 1'b1;
          state_d       = IDLE;
        end
      end
      PAD: begin
        dtw_fifo_din = '1;
        if (!dtw_fifo_full) begin
          dtw_fifo_wren = 1'b1;
          if (word_cnt == LAST_WORD) begin
            pend_clear = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE) || flush_pend;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state          <= IDLE;
      last_grant     <= LAST_CORE;
      idx_q          <= '0;
      score_q        <= '0;
      pos_q          <= '0;
      word_cnt       <= '0;
      flush_pend     <= 1'b0;
      results_sent   <= '0;
      core_res_ready <= '0;
    end else begin
      state          <= state_d;
      core_res_ready <= '0;
      if (take_grant) begin
        idx_q          <= grant_idx;
        last_grant     <= grant_idx;
        score_q        <= core_res_score[grant_idx*C_DATA_WIDTH +: C_DATA_WIDTH];
        pos_q          <= core_res_pos[grant_idx*POS_WIDTH +: POS_WIDTH];
        core_res_ready <= NUM_CORES'(1) << grant_idx;
      end
      if (dtw_fifo_wren) word_cnt <= word_cnt + WC_W'(1);
      // A new request outranks a same-cycle retirement so it is never lost.
      if (flush)           flush_pend <= 1'b1;
      else if (pend_clear) flush_pend <= 1'b0;
      if (state == SCORE && dtw_fifo_wren) results_sent <= results_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_dtw_result_arbiter.sv
// Self-checking bench for dtw_result_arbiter. A core-side driver answers ready
// pulses, and a scoreboard predicts the FIFO word stream from the arbitration,
// packet and flush rules. Scenario tasks add targeted checks on top.
module tb_dtw_result_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int PW  = 24;
  localparam int PKT = 8;
  localparam logic [DW-1:0] PAD_WORD = 32'hFFFF_FFFF;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic [N-1:0]      core_res_valid = '0;
  logic [N-1:0]      core_res_ready;
  logic [N*DW-1:0]   core_res_score = '0;
  logic [N*PW-1:0]   core_res_pos = '0;
  logic              flush = 1'b0;
  logic              dtw_fifo_wren;
  logic [DW-1:0]     dtw_fifo_din;
  logic              dtw_fifo_full = 1'b0;
  logic              busy;
  logic [15:0]       results_sent;

  always #5 ACLK = ~ACLK;

  dtw_result_arbiter #(
    .NUM_CORES(N), .C_DATA_WIDTH(DW), .POS_WIDTH(PW), .PACKET_WORDS(PKT)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .core_res_valid(core_res_valid), .core_res_ready(core_res_ready),
    .core_res_score(core_res_score), .core_res_pos(core_res_pos),
    .flush(flush),
    .dtw_fifo_wren(dtw_fifo_wren), .dtw_fifo_din(dtw_fifo_din),
    .dtw_fifo_full(dtw_fifo_full),
    .busy(busy), .results_sent(results_sent)
  );

  typedef struct {
    int            core;
    logic [DW-1:0] s;
    logic [PW-1:0] p;
  } req_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Core side: pending requests and the data each core currently presents.
  req_t          req_q[$];
  logic [DW-1:0] cur_s[N];
  logic [PW-1:0] cur_p[N];

  // Reference model state.
  logic [DW-1:0] exp_q[$];
  bit            exp_is_score[$];
  int            m_last    = N - 1;
  int            m_words   = 0;
  int            m_results = 0;
  bit            m_fpend   = 1'b0;
  logic [N-1:0]  vsnap     = '0;
  bit            fsnap     = 1'b0;

  // Observation logs for scenario checks.
  int            grant_log[$];
  int            wr_cyc[$];
  logic [DW-1:0] wr_dat[$];
  int            ready_pulses = 0;

  function automatic logic [DW-1:0] mk_hdr(int c, logic [PW-1:0] p);
    return (32'hD << 28) | (32'(c) << 24) | 32'(p);
  endfunction

  task automatic sample_loop();
    forever begin
      @(posedge ACLK);
      cyc++;
      vsnap = core_res_valid;
      fsnap = flush;
    end
  endtask

  // Core driver and scoreboard, evaluated once per cycle after inputs settle.
  task automatic monitor_loop();
    bit           acked[N];
    logic [N-1:0] prev_ready;
    int           exp_g;
    int           obs_g;
    int           c;
    int           pads;
    logic [DW-1:0] ed;
    bit           is_sc;
    prev_ready = '0;
    forever begin
      @(negedge ACLK);
      #1;
      for (int i = 0; i < N; i++) acked[i] = 1'b0;
      if (ARESET) begin
        exp_q.delete();
        exp_is_score.delete();
        m_words   = 0;
        m_last    = N - 1;
        m_results = 0;
        m_fpend   = 1'b0;
        core_res_valid = '0;
        prev_ready = '0;
      end else begin
        if (core_res_ready != '0) begin
          exp_g = -1;
          for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (exp_g < 0 && vsnap[c]) exp_g = c;
          end
          obs_g = -1;
          for (int i = 0; i < N; i++) if (core_res_ready[i]) obs_g = i;
          checks++;
          if (exp_g < 0 || core_res_ready !== (N'(1) << exp_g) || (core_res_ready & prev_ready) != '0) begin
            failures++;
            $display("FAIL grant: ready=%b required core %0d (valid at grant %b, previous ready %b)",
                     core_res_ready, exp_g, vsnap, prev_ready);
          end
          if (exp_g >= 0) begin
            exp_q.push_back(mk_hdr(exp_g, cur_p[exp_g]));
            exp_is_score.push_back(1'b0);
            exp_q.push_back(cur_s[exp_g]);
            exp_is_score.push_back(1'b1);
            m_words += 2;
            m_last  = exp_g;
          end
          if (obs_g >= 0) begin
            grant_log.push_back(obs_g);
            ready_pulses++;
            for (int i = 0; i < N; i++)
              if (core_res_ready[i]) begin
                core_res_valid[i] = 1'b0;
                acked[i] = 1'b1;
              end
          end
        end
        prev_ready = core_res_ready;

        if (dtw_fifo_wren) begin
          checks++;
          if (dtw_fifo_full) begin
            failures++;
            $display("FAIL write_while_full: wren=1 with full=1, din=%h", dtw_fifo_din);
          end else if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: din=%h, required no write", dtw_fifo_din);
          end else begin
            ed    = exp_q.pop_front();
            is_sc = exp_is_score.pop_front();
            if (is_sc) m_results++;
            if (dtw_fifo_din !== ed) begin
              failures++;
              $display("FAIL write_data: din=%h required %h", dtw_fifo_din, ed);
            end
          end
          wr_cyc.push_back(cyc);
          wr_dat.push_back(dtw_fifo_din);
        end

        // A flush is served once every record already accepted has been written.
        if (fsnap) m_fpend = 1'b1;
        if (m_fpend && exp_q.size() == 0) begin
          pads = (PKT - (m_words % PKT)) % PKT;
          for (int i = 0; i < pads; i++) begin
            exp_q.push_back(PAD_WORD);
            exp_is_score.push_back(1'b0);
          end
          m_words += pads;
          m_fpend = 1'b0;
        end

        for (int i = 0; i < N; i++) begin
          if (!core_res_valid[i] && !acked[i]) begin
            for (int j = 0; j < req_q.size(); j++) begin
              if (req_q[j].core == i) begin
                cur_s[i] = req_q[j].s;
                cur_p[i] = req_q[j].p;
                core_res_score[i*DW +: DW] = req_q[j].s;
                core_res_pos[i*PW +: PW]   = req_q[j].p;
                core_res_valid[i] = 1'b1;
                req_q.delete(j);
                break;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic request(input int c, input logic [DW-1:0] s, input logic [PW-1:0] p);
    req_t r;
    r.core = c;
    r.s    = s;
    r.p    = p;
    req_q.push_back(r);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    wr_cyc.delete();
    wr_dat.delete();
    ready_pulses = 0;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET        = 1'b1;
    flush         = 1'b0;
    dtw_fifo_full = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge ACLK);
    flush = 1'b1;
    @(negedge ACLK);
    flush = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge ACLK);
      #2;
      if (exp_q.size() == 0 && req_q.size() == 0 && core_res_valid == '0 && !busy && !m_fpend) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge ACLK);
    #2;
    checks++;
    if ({core_res_ready, dtw_fifo_wren, busy} !== '0 || dtw_fifo_din !== '0 || results_sent !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b wren=%b busy=%b din=%h sent=%0d required all 0",
               core_res_ready, dtw_fifo_wren, busy, dtw_fifo_din, results_sent);
    end
    ARESET = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    clear_logs();
    request(2, 32'h0000_1234, 24'h00ABCD);
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_idle: timed out, required idle"); end
    checks++;
    if (ready_pulses != 1 || grant_log.size() != 1 || grant_log[0] != 2) begin
      failures++;
      $display("FAIL single_ready: pulses=%0d first grant=%0d required 1 pulse to core 2",
               ready_pulses, grant_log.size() > 0 ? grant_log[0] : -1);
    end
    checks++;
    if (wr_dat.size() != 2) begin
      failures++;
      $display("FAIL single_count: writes=%0d required 2", wr_dat.size());
    end else begin
      if (wr_dat[0] !== 32'hD200ABCD) begin
        failures++;
        $display("FAIL single_header: %h required d200abcd", wr_dat[0]);
      end
      checks++;
      if (wr_dat[1] !== 32'h0000_1234) begin
        failures++;
        $display("FAIL single_score: %h required 00001234", wr_dat[1]);
      end
      checks++;
      if (wr_cyc[1] - wr_cyc[0] != 1) begin
        failures++;
        $display("FAIL single_spacing: %0d cycles between writes, required 1", wr_cyc[1] - wr_cyc[0]);
      end
    end
    checks++;
    if (results_sent !== 16'd1) begin
      failures++;
      $display("FAIL single_results: %0d required 1", results_sent);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int order[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    clear_logs();
    for (int i = 0; i < 6; i++) request(order[i], $urandom, PW'($urandom));
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rr_idle: timed out, required idle"); end
    checks++;
    if (grant_log.size() != 6) begin
      failures++;
      $display("FAIL rr_count: %0d grants required 6", grant_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (i > 0) checks++;
        if (grant_log[i] != order[i]) begin
          failures++;
          $display("FAIL rr_order[%0d]: core %0d required %0d", i, grant_log[i], order[i]);
        end
      end
    end
    checks++;
    if (wr_cyc.size() != 12 || wr_cyc[7] - wr_cyc[0] != 10) begin
      failures++;
      $display("FAIL rr_packet_timing: writes=%0d span=%0d required 12 writes, first packet span 10",
               wr_cyc.size(), wr_cyc.size() >= 8 ? wr_cyc[7] - wr_cyc[0] : -1);
    end
    checks++;
    if (results_sent !== 16'd6) begin
      failures++;
      $display("FAIL rr_results: %0d required 6", results_sent);
    end
  endtask

  task automatic test_backpressure();
    bit            ok;
    bit            seen;
    logic [DW-1:0] s;
    logic [PW-1:0] p;
    logic [DW-1:0] hdr;
    clear_logs();
    s   = $urandom;
    p   = PW'($urandom);
    hdr = mk_hdr(1, p);
    @(negedge ACLK);
    dtw_fifo_full = 1'b1;
    request(1, s, p);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ACLK);
      #2;
      seen = (ready_pulses > 0);
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL bp_grant: no ready within 20 cycles, required one"); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge ACLK); #2; end
      checks++;
      if (dtw_fifo_wren !== 1'b0 || dtw_fifo_din !== hdr) begin
        failures++;
        $display("FAIL bp_hold[%0d]: wren=%b din=%h required wren=0 din=%h", i, dtw_fifo_wren, dtw_fifo_din, hdr);
      end
    end
    @(negedge ACLK);
    dtw_fifo_full = 1'b0;
    #2;
    checks++;
    if (dtw_fifo_wren !== 1'b1 || dtw_fifo_din !== hdr) begin
      failures++;
      $display("FAIL bp_release: wren=%b din=%h required wren=1 din=%h", dtw_fifo_wren, dtw_fifo_din, hdr);
    end
    wait_idle(ok);
    checks++;
    if (!ok || wr_dat.size() != 2 || wr_dat[1] !== s) begin
      failures++;
      $display("FAIL bp_score: idle=%b writes=%0d score=%h required idle, 2 writes, score %h",
               ok, wr_dat.size(), wr_dat.size() > 1 ? wr_dat[1] : '0, s);
    end
  endtask

  task automatic test_flush();
    bit            ok;
    int            pads;
    logic [DW-1:0] s;
    bit            seen;
    // One record leaves the packet two words in; the flush must add six pads.
    do_reset();
    clear_logs();
    request(int'($urandom_range(0, N - 1)), $urandom, PW'($urandom));
    wait_idle(ok);
    pulse_flush();
    wait_idle(ok);
    pads = 0;
    for (int i = 0; i < wr_dat.size(); i++) if (wr_dat[i] === PAD_WORD) pads++;
    checks++;
    if (!ok || wr_dat.size() != 8 || pads != 6 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_partial: idle=%b writes=%0d pads=%0d busy=%b required 8 writes, 6 pads, busy 0",
               ok, wr_dat.size(), pads, busy);
    end

    // At a packet boundary the flush only retires: busy for one cycle, no writes.
    clear_logs();
    pulse_flush();
    #2;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL flush_pending: busy=%b required 1", busy); end
    wait_idle(ok);
    checks++;
    if (!ok || wr_dat.size() != 0) begin
      failures++;
      $display("FAIL flush_boundary: idle=%b writes=%0d required idle with 0 writes", ok, wr_dat.size());
    end

    // Flush raised while the score is being written: pads follow the score.
    clear_logs();
    s = $urandom;
    request(3, s, PW'($urandom));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ACLK);
      #2;
      seen = (wr_dat.size() >= 1);
    end
    @(negedge ACLK);
    flush = 1'b1;
    @(negedge ACLK);
    flush = 1'b0;
    wait_idle(ok);
    pads = 0;
    for (int i = 2; i < wr_dat.size(); i++) if (wr_dat[i] === PAD_WORD) pads++;
    checks++;
    if (!seen || !ok || wr_dat.size() != 8 || wr_dat[1] !== s || pads != 6 || wr_cyc[2] <= wr_cyc[1]) begin
      failures++;
      $display("FAIL flush_in_score: writes=%0d score=%h pads=%0d required 8 writes, score %h, then 6 pads",
               wr_dat.size(), wr_dat.size() > 1 ? wr_dat[1] : '0, pads, s);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    clear_logs();
    request(0, $urandom, PW'($urandom));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ACLK);
      #2;
      seen = (wr_dat.size() >= 1);
    end
    @(posedge ACLK);
    #2;
    ARESET = 1'b1;
    #1;
    checks++;
    if (!seen || {core_res_ready, dtw_fifo_wren, busy} !== '0 || dtw_fifo_din !== '0 || results_sent !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid: header_seen=%b ready=%b wren=%b busy=%b din=%h sent=%0d required all 0",
               seen, core_res_ready, dtw_fifo_wren, busy, dtw_fifo_din, results_sent);
    end
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    clear_logs();
    request(3, $urandom, PW'($urandom));
    request(0, $urandom, PW'($urandom));
    wait_idle(ok);
    checks++;
    if (!ok || grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 3) begin
      failures++;
      $display("FAIL reset_grant: idle=%b grants=%0d first=%0d required core 0 then 3",
               ok, grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
    end
  endtask

  task automatic test_random();
    bit ok;
    clear_logs();
    for (int i = 0; i < 600; i++) begin
      @(negedge ACLK);
      dtw_fifo_full = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 40) == 0);
      if (req_q.size() < 6 && $urandom_range(0, 2) == 0)
        request(int'($urandom_range(0, N - 1)), $urandom, PW'($urandom));
    end
    @(negedge ACLK);
    flush         = 1'b0;
    dtw_fifo_full = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || results_sent !== 16'(m_results) || ready_pulses == 0) begin
      failures++;
      $display("FAIL random: idle=%b results_sent=%0d required %0d (grants %0d)",
               ok, results_sent, m_results, ready_pulses);
    end
  endtask

  initial begin
    fork
      sample_loop();
      monitor_loop();
      begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join
  end

endmodule
